// File: rtl/ipcu_pkg.sv
// Shared definitions for the input-port control unit: sequencer state
// encodings and the counter-width helper.
package ipcu_pkg;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_BODY = 1'b1
  } seq_state_t;

  // Writer and reader run the same sequencer; these name its states per role.
  localparam seq_state_t WIDLE = SEQ_IDLE;
  localparam seq_state_t WBODY = SEQ_BODY;
  localparam seq_state_t RIDLE = SEQ_IDLE;
  localparam seq_state_t RBODY = SEQ_BODY;

  // Flit down-counter width: enough bits to hold FLITS-1, never zero.
  function automatic int cnt_w(input int n);
    int c;
    c = $clog2(n);
    return (c > 1) ? c : 1;
  endfunction

endpackage

// File: rtl/ipcu_param_pkt_seq.sv
// Packet sequencer: on start emits one strobe per flit for FLITS cycles,
// flagging the first (head) and last flit.
module pkt_seq
  import ipcu_pkg::*;
#(
  parameter int         FLITS  = 4,
  parameter seq_state_t IDLE_S = SEQ_IDLE,
  parameter seq_state_t BODY_S = SEQ_BODY
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic strobe,
  output logic first,
  output logic last,
  output logic idle
);

  localparam int            CW   = cnt_w(FLITS);
  localparam logic [CW-1:0] LOAD = CW'(FLITS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  seq_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE_S;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The head flit goes out in the start cycle; cnt then counts the
  // remaining flits down to 1, so it never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    strobe    = 1'b0;
    first     = 1'b0;
    last      = 1'b0;
    idle      = (state == IDLE_S);
    case (state)
      IDLE_S: begin
        if (start) begin
          strobe    = 1'b1;
          first     = 1'b1;
          cnt_nxt   = LOAD;
          state_nxt = BODY_S;
        end
      end
      BODY_S: begin
        strobe = 1'b1;
        if (cnt == ONE) begin
          last      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE_S;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      default: begin
        state_nxt = IDLE_S;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/ipcu_param.sv
// Input-port control unit: writes incoming packets into a DEPTH-slot buffer,
// requests the arbiter and reads packets out, store-and-forward or cut-through.
module ipcu_param
  import ipcu_pkg::*;
#(
  parameter int FLITS       = 4,
  parameter int DEPTH       = 4,
  parameter int CUT_THROUGH = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_en,
  input  logic                       arb_ack,
  output logic                       wr_strobe,
  output logic                       wr_last,
  output logic                       rd_strobe,
  output logic                       crt_out,
  output logic                       rd_last,
  output logic                       rqs_strobe,
  output logic                       in_ready,
  output logic                       drop_err,
  output logic [$clog2(DEPTH+1)-1:0] pkt_cnt
);

  localparam int            PW    = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P = PW'(1);

  logic          wr_go;
  logic          head_wr;
  logic          w_idle;
  logic          r_idle;
  logic          grant;
  logic          pend_inc;
  logic [PW-1:0] pend;

  assign in_ready   = (pkt_cnt < DEPTH_V);
  assign wr_go      = pipe_en & in_ready;
  // A head arriving while the writer is mid-packet is ignored, not an error.
  assign drop_err   = pipe_en & w_idle & ~in_ready;
  assign rqs_strobe = (pend != '0) & r_idle;
  assign grant      = rqs_strobe & arb_ack;
  // Cut-through exposes a packet on its head write; pend registers it, so
  // the earliest read lands one cycle after the head write.
  assign pend_inc   = (CUT_THROUGH != 0) ? head_wr : wr_last;

  pkt_seq #(
    .FLITS  (FLITS),
    .IDLE_S (WIDLE),
    .BODY_S (WBODY)
  ) u_writer (
    .clk    (clk),
    .rst    (rst),
    .start  (wr_go),
    .strobe (wr_strobe),
    .first  (head_wr),
    .last   (wr_last),
    .idle   (w_idle)
  );

  pkt_seq #(
    .FLITS  (FLITS),
    .IDLE_S (RIDLE),
    .BODY_S (RBODY)
  ) u_reader (
    .clk    (clk),
    .rst    (rst),
    .start  (grant),
    .strobe (rd_strobe),
    .first  (crt_out),
    .last   (rd_last),
    .idle   (r_idle)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
      pend    <= '0;
    end else begin
      case ({head_wr, rd_last})
        2'b10:   pkt_cnt <= pkt_cnt + ONE_P;
        2'b01:   pkt_cnt <= pkt_cnt - ONE_P;
        default: pkt_cnt <= pkt_cnt;
      endcase
      case ({pend_inc, grant})
        2'b10:   pend <= pend + ONE_P;
        2'b01:   pend <= pend - ONE_P;
        default: pend <= pend;
      endcase
    end
  end

endmodule

// File: tb/tb_ipcu_param.sv
// Directed bench for ipcu_param (FLITS=4, DEPTH=2): per-cycle vector table
// on a store-and-forward instance plus a cut-through request sequence.
module tb_ipcu_param;

  logic clk = 1'b0;
  logic rst, pipe_en, arb_ack;

  logic       ws, wl, rs, co, rl, rq, ir, de;
  logic [1:0] pc;
  logic       ct_ws, ct_wl, ct_rs, ct_co, ct_rl, ct_rq, ct_ir, ct_de;
  logic [1:0] ct_pc;

  always #5 clk = ~clk;

  ipcu_param #(.FLITS(4), .DEPTH(2), .CUT_THROUGH(0)) dut_sf (
    .clk(clk), .rst(rst), .pipe_en(pipe_en), .arb_ack(arb_ack),
    .wr_strobe(ws), .wr_last(wl), .rd_strobe(rs), .crt_out(co),
    .rd_last(rl), .rqs_strobe(rq), .in_ready(ir), .drop_err(de),
    .pkt_cnt(pc)
  );

  ipcu_param #(.FLITS(4), .DEPTH(2), .CUT_THROUGH(1)) dut_ct (
    .clk(clk), .rst(rst), .pipe_en(pipe_en), .arb_ack(arb_ack),
    .wr_strobe(ct_ws), .wr_last(ct_wl), .rd_strobe(ct_rs), .crt_out(ct_co),
    .rd_last(ct_rl), .rqs_strobe(ct_rq), .in_ready(ct_ir), .drop_err(ct_de),
    .pkt_cnt(ct_pc)
  );

  typedef struct {
    bit       r;
    bit       p;
    bit       a;
    bit [7:0] ex;   // {ws, wl, rs, co, rl, rq, ir, de}
    int       pc;
    bit       chk;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   row    = 0;

  function automatic vec_t v(bit r, bit p, bit a, bit [7:0] ex, int pcnt, bit c);
    vec_t t;
    t.r = r; t.p = p; t.a = a; t.ex = ex; t.pc = pcnt; t.chk = c;
    return t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", nm, row, act, exp);
    end
  endtask

  initial begin
    bit [3:0] ct_exp [6];
    rst = 1'b0; pipe_en = 1'b0; arb_ack = 1'b0;

    // Reset and reset state
    tbl.push_back(v(1,0,0,8'b0000_0000,0,0));
    tbl.push_back(v(0,0,0,8'b0000_0010,0,1));
    // Store-and-forward single packet, stray grant at cycle 1, grant at 6
    tbl.push_back(v(0,1,0,8'b1000_0010,0,1));
    tbl.push_back(v(0,0,1,8'b1000_0010,1,1));
    tbl.push_back(v(0,0,0,8'b1000_0010,1,1));
    tbl.push_back(v(0,0,0,8'b1100_0010,1,1));
    tbl.push_back(v(0,0,0,8'b0000_0110,1,1));
    tbl.push_back(v(0,0,0,8'b0000_0110,1,1));
    tbl.push_back(v(0,0,1,8'b0011_0110,1,1));
    tbl.push_back(v(0,0,0,8'b0010_0010,1,1));
    tbl.push_back(v(0,0,0,8'b0010_0010,1,1));
    tbl.push_back(v(0,0,0,8'b0010_1010,1,1));
    tbl.push_back(v(0,0,0,8'b0000_0010,0,1));
    // Fill to DEPTH, head during body ignored, head when full dropped
    tbl.push_back(v(0,1,0,8'b1000_0010,0,1));
    tbl.push_back(v(0,0,0,8'b1000_0010,1,1));
    tbl.push_back(v(0,0,0,8'b1000_0010,1,1));
    tbl.push_back(v(0,0,0,8'b1100_0010,1,1));
    tbl.push_back(v(0,1,0,8'b1000_0110,1,1));
    tbl.push_back(v(0,0,0,8'b1000_0100,2,1));
    tbl.push_back(v(0,1,0,8'b1000_0100,2,1));
    tbl.push_back(v(0,0,0,8'b1100_0100,2,1));
    tbl.push_back(v(0,1,0,8'b0000_0101,2,1));
    tbl.push_back(v(0,0,0,8'b0000_0100,2,1));
    // Back-to-back drain with grant held high
    tbl.push_back(v(0,0,1,8'b0011_0100,2,1));
    tbl.push_back(v(0,0,1,8'b0010_0000,2,1));
    tbl.push_back(v(0,0,1,8'b0010_0000,2,1));
    tbl.push_back(v(0,0,1,8'b0010_1000,2,1));
    tbl.push_back(v(0,0,1,8'b0011_0110,1,1));
    tbl.push_back(v(0,0,1,8'b0010_0010,1,1));
    tbl.push_back(v(0,0,1,8'b0010_0010,1,1));
    tbl.push_back(v(0,0,1,8'b0010_1010,1,1));
    tbl.push_back(v(0,0,1,8'b0000_0010,0,1));
    // Head write coinciding with rd_last
    tbl.push_back(v(0,1,0,8'b1000_0010,0,1));
    tbl.push_back(v(0,0,0,8'b1000_0010,1,1));
    tbl.push_back(v(0,0,0,8'b1000_0010,1,1));
    tbl.push_back(v(0,0,0,8'b1100_0010,1,1));
    tbl.push_back(v(0,0,1,8'b0011_0110,1,1));
    tbl.push_back(v(0,0,0,8'b0010_0010,1,1));
    tbl.push_back(v(0,0,0,8'b0010_0010,1,1));
    tbl.push_back(v(0,1,0,8'b1010_1010,1,1));
    tbl.push_back(v(0,0,0,8'b1000_0010,1,1));
    tbl.push_back(v(0,0,0,8'b1000_0010,1,1));
    tbl.push_back(v(0,0,0,8'b1100_0010,1,1));
    tbl.push_back(v(0,0,0,8'b0000_0110,1,1));
    // Reset mid-packet, then a fresh packet
    tbl.push_back(v(0,1,0,8'b1000_0110,1,1));
    tbl.push_back(v(0,0,0,8'b1000_0100,2,1));
    tbl.push_back(v(1,0,0,8'b0000_0000,0,0));
    tbl.push_back(v(0,0,0,8'b0000_0010,0,1));
    tbl.push_back(v(0,1,0,8'b1000_0010,0,1));
    tbl.push_back(v(0,0,0,8'b1000_0010,1,1));
    tbl.push_back(v(0,0,0,8'b1000_0010,1,1));
    tbl.push_back(v(0,0,0,8'b1100_0010,1,1));
    tbl.push_back(v(0,0,0,8'b0000_0110,1,1));

    foreach (tbl[i]) begin
      @(negedge clk);
      row     = i;
      rst     = tbl[i].r;
      pipe_en = tbl[i].p;
      arb_ack = tbl[i].a;
      #2;
      if (tbl[i].chk) begin
        chk("wr_strobe",  int'(ws), int'(tbl[i].ex[7]));
        chk("wr_last",    int'(wl), int'(tbl[i].ex[6]));
        chk("rd_strobe",  int'(rs), int'(tbl[i].ex[5]));
        chk("crt_out",    int'(co), int'(tbl[i].ex[4]));
        chk("rd_last",    int'(rl), int'(tbl[i].ex[3]));
        chk("rqs_strobe", int'(rq), int'(tbl[i].ex[2]));
        chk("in_ready",   int'(ir), int'(tbl[i].ex[1]));
        chk("drop_err",   int'(de), int'(tbl[i].ex[0]));
        chk("pkt_cnt",    int'(pc), tbl[i].pc);
      end
    end

    // Cut-through: head at g0 with grant held high; expected {rq, rs, co, rl}
    ct_exp[0] = 4'b0000;
    ct_exp[1] = 4'b1110;
    ct_exp[2] = 4'b0100;
    ct_exp[3] = 4'b0100;
    ct_exp[4] = 4'b0101;
    ct_exp[5] = 4'b0000;
    @(negedge clk);
    rst = 1'b1; pipe_en = 1'b0; arb_ack = 1'b0;
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      row     = 1000 + g;
      rst     = 1'b0;
      pipe_en = (g == 0);
      arb_ack = 1'b1;
      #2;
      chk("ct_rqs_strobe", int'(ct_rq), int'(ct_exp[g][3]));
      chk("ct_rd_strobe",  int'(ct_rs), int'(ct_exp[g][2]));
      chk("ct_crt_out",    int'(ct_co), int'(ct_exp[g][1]));
      chk("ct_rd_last",    int'(ct_rl), int'(ct_exp[g][0]));
      if (g == 0) chk("ct_wr_strobe", int'(ct_ws), 1);
    end
    @(negedge clk);
    row = 1006;
    arb_ack = 1'b0;
    #2;
    chk("ct_pkt_cnt", int'(ct_pc), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
